// File: rtl/tx_src_arbiter.sv
// Round-robin arbiter sharing the TX FIFO write port between the CPU write buffer
// and a DMA byte stream, with bounded bursts per grant and a running byte count.
module tx_src_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cpu_empty,
  input  logic             cpu_wr,
  input  logic [7:0]       cpu_q,
  output logic             cpu_has_space,
  input  logic             dma_valid,
  input  logic [7:0]       dma_data,
  output logic             dma_ready,
  input  logic             fifo_full,
  output logic             fifo_wr,
  output logic [7:0]       fifo_wdata,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] tx_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_CPU,
    GRANT_DMA
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_MAX - 1);

  state_t     state;
  logic       last_dma;
  logic [7:0] beats;
  logic       cpu_xfer;
  logic       dma_xfer;

  // Handshakes are combinational so a byte is written in the same cycle it is accepted.
  always_comb begin
    cpu_has_space = (state == GRANT_CPU) && enable && !fifo_full;
    dma_ready     = (state == GRANT_DMA) && enable && !fifo_full;
    cpu_xfer      = cpu_has_space && !cpu_empty && !cpu_wr;
    dma_xfer      = dma_ready && dma_valid;
    fifo_wr       = cpu_xfer || dma_xfer;
    if (cpu_xfer)
      fifo_wdata = cpu_q;
    else if (dma_xfer)
      fifo_wdata = dma_data;
    else
      fifo_wdata = 8'h00;
  end

  assign busy = (state != IDLE);

  // Every grant returns through IDLE, giving the one-cycle bubble between bursts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_dma <= 1'b1;
      beats    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            if (!cpu_empty && dma_valid) begin
              state <= last_dma ? GRANT_CPU : GRANT_DMA;
              beats <= 8'd0;
            end else if (!cpu_empty) begin
              state <= GRANT_CPU;
              beats <= 8'd0;
            end else if (dma_valid) begin
              state <= GRANT_DMA;
              beats <= 8'd0;
            end
          end
        end
        GRANT_CPU: begin
          if (!enable || (cpu_xfer && beats == LAST_BEAT) || (!cpu_xfer && cpu_empty)) begin
            state    <= IDLE;
            last_dma <= 1'b0;
          end else if (cpu_xfer) begin
            beats <= beats + 8'd1;
          end
        end
        GRANT_DMA: begin
          if (!enable || (dma_xfer && beats == LAST_BEAT) || (!dma_xfer && !dma_valid)) begin
            state    <= IDLE;
            last_dma <= 1'b1;
          end else if (dma_xfer) begin
            beats <= beats + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tx_count <= '0;
    else if (cnt_clr)
      tx_count <= '0;
    else if (fifo_wr)
      tx_count <= tx_count + 1'b1;
  end

endmodule
